// File: rtl/meter_channel_scheduler.sv
// Round-robin scheduler serialising per-channel meter arrays onto one tagged output stream.
// Optional periodic re-emission of stored arrays is enabled by defining METER_SCHED_REFRESH_EN.
module meter_channel_scheduler #(
  parameter int channel_count   = 2,
  parameter int indicator_width = 32,
  parameter int refresh_period  = 1000000,
  localparam int CW = (channel_count > 1) ? $clog2(channel_count) : 1
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [channel_count-1:0]                 i_valid,
  output logic [channel_count-1:0]                 i_ready,
  input  logic [channel_count*indicator_width-1:0] i_array,
  output logic                                     o_valid,
  input  logic                                     o_ready,
  output logic [CW-1:0]                            o_channel,
  output logic [indicator_width-1:0]               o_array
);

  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t                     state_r;
  state_t                     state_s;
  logic [channel_count-1:0]   pending_r;
  logic [channel_count-1:0]   capture_s;
  logic [channel_count-1:0]   grant_clr_s;
  logic [channel_count-1:0]   refresh_set_s;
  logic [channel_count-1:0]   rot_s;
  logic [indicator_width-1:0] buf_r [channel_count];
  logic [CW-1:0]              rr_r;
  logic [CW-1:0]              offset_s;
  logic [CW-1:0]              grant_idx_s;
  logic [CW:0]                sum_s;
  logic                       grant_found_s;
  logic                       grant_s;
  logic                       done_s;

  assign i_ready     = ~pending_r;
  assign capture_s   = i_valid & ~pending_r;
  assign grant_clr_s = grant_s ? ({{(channel_count-1){1'b0}}, 1'b1} << grant_idx_s)
                               : {channel_count{1'b0}};

  // Rotate pending so offset 0 is the rr channel, then pick the lowest set offset
  always_comb begin
    rot_s         = channel_count'({pending_r, pending_r} >> rr_r);
    grant_found_s = 1'b0;
    offset_s      = {CW{1'b0}};
    for (int i = channel_count - 1; i >= 0; i--) begin
      offset_s      = rot_s[i] ? CW'(i) : offset_s;
      grant_found_s = grant_found_s | rot_s[i];
    end
    sum_s       = {1'b0, rr_r} + {1'b0, offset_s};
    grant_idx_s = (sum_s >= (CW+1)'(channel_count)) ? CW'(sum_s - (CW+1)'(channel_count))
                                                    : sum_s[CW-1:0];
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state and grant/complete strobes
  always_comb begin
    state_s = state_r;
    grant_s = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (grant_found_s) begin
          grant_s = 1'b1;
          state_s = SEND;
        end else begin
          state_s = IDLE;
        end
      end
      SEND: begin
        if (o_valid && o_ready) begin
          done_s  = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = SEND;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Buffers, pending flags, round-robin pointer and registered output stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_r <= {channel_count{1'b0}};
      rr_r      <= {CW{1'b0}};
      o_valid   <= 1'b0;
      o_channel <= {CW{1'b0}};
      o_array   <= {indicator_width{1'b0}};
      for (int c = 0; c < channel_count; c++) begin
        buf_r[c] <= {indicator_width{1'b0}};
      end
    end else begin
      // a refresh wrap coinciding with a grant keeps the channel pending
      pending_r <= (pending_r & ~grant_clr_s) | capture_s | refresh_set_s;
      for (int c = 0; c < channel_count; c++) begin
        if (capture_s[c]) begin
          buf_r[c] <= i_array[c*indicator_width +: indicator_width];
        end
      end
      if (grant_s) begin
        o_valid   <= 1'b1;
        o_channel <= grant_idx_s;
        o_array   <= buf_r[grant_idx_s];
      end else if (done_s) begin
        o_valid <= 1'b0;
        rr_r    <= (o_channel == CW'(channel_count - 1)) ? {CW{1'b0}} : o_channel + {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end

`ifdef METER_SCHED_REFRESH_EN
  localparam int RW = (refresh_period > 1) ? $clog2(refresh_period) : 1;

  logic [RW-1:0]            refresh_cnt_r;
  logic [channel_count-1:0] stored_r;
  logic                     wrap_s;

  assign wrap_s        = (refresh_cnt_r == RW'(refresh_period - 1));
  assign refresh_set_s = wrap_s ? stored_r : {channel_count{1'b0}};

  // Free-running refresh counter and per-channel "has data" flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh_cnt_r <= {RW{1'b0}};
      stored_r      <= {channel_count{1'b0}};
    end else begin
      refresh_cnt_r <= wrap_s ? {RW{1'b0}} : refresh_cnt_r + {{(RW-1){1'b0}}, 1'b1};
      stored_r      <= stored_r | capture_s;
    end
  end
`else
  assign refresh_set_s = {channel_count{1'b0}};
`endif

endmodule

// File: tb/tb_meter_channel_scheduler.sv
// Directed self-checking bench for meter_channel_scheduler (4 channels, 32-bit arrays).
module tb_meter_channel_scheduler;
  localparam int CH = 4;
  localparam int IW = 32;
  localparam int CW = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [CH-1:0]    i_valid;
  logic [CH-1:0]    i_ready;
  logic [CH*IW-1:0] i_array;
  logic             o_valid;
  logic             o_ready;
  logic [CW-1:0]    o_channel;
  logic [IW-1:0]    o_array;

  int errors = 0;
  int checks = 0;
  int emits;

  meter_channel_scheduler #(
    .channel_count(CH), .indicator_width(IW), .refresh_period(16)
  ) dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_ready(i_ready), .i_array(i_array),
    .o_valid(o_valid), .o_ready(o_ready), .o_channel(o_channel), .o_array(o_array)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    i_valid = '0;
    i_array = '0;
    o_ready = 1'b0;
    do_reset();

    check("rst_o_valid", 64'(o_valid), 64'd0);
    check("rst_o_channel", 64'(o_channel), 64'd0);
    check("rst_o_array", 64'(o_array), 64'd0);
    check("rst_i_ready", 64'(i_ready), 64'hF);

    // single capture on channel 1
    i_array[1*IW +: IW] = 32'h0000FFFF;
    i_valid = 4'b0010;
    step();
    i_valid = '0;
    check("cap_i_ready", 64'(i_ready), 64'hD);
    check("cap_o_valid_early", 64'(o_valid), 64'd0);
    step();
    check("cap_o_valid", 64'(o_valid), 64'd1);
    check("cap_o_channel", 64'(o_channel), 64'd1);
    check("cap_o_array", 64'(o_array), 64'h0000FFFF);
    check("cap_i_ready_back", 64'(i_ready), 64'hF);

    // backpressure: outputs hold while a newer array for channel 1 is captured
    for (int i = 0; i < 10; i++) begin
      if (i == 2) begin
        i_array[1*IW +: IW] = 32'h12345678;
        i_valid = 4'b0010;
      end else begin
        i_valid = '0;
      end
      step();
      check("bp_o_valid", 64'(o_valid), 64'd1);
      check("bp_o_channel", 64'(o_channel), 64'd1);
      check("bp_o_array", 64'(o_array), 64'h0000FFFF);
    end
    check("bp_i_ready", 64'(i_ready), 64'hD);
    o_ready = 1'b1;
    step();
    check("bp_done_o_valid", 64'(o_valid), 64'd0);
    o_ready = 1'b0;
    step();
    check("bp_next_o_valid", 64'(o_valid), 64'd1);
    check("bp_next_o_channel", 64'(o_channel), 64'd1);
    check("bp_next_o_array", 64'(o_array), 64'h12345678);

    // reset while SEND holds a transfer
    reset = 1'b1;
    #1;
    check("mid_rst_o_valid", 64'(o_valid), 64'd0);
    check("mid_rst_o_channel", 64'(o_channel), 64'd0);
    check("mid_rst_o_array", 64'(o_array), 64'd0);
    check("mid_rst_i_ready", 64'(i_ready), 64'hF);
    repeat (2) step();
    reset   = 1'b0;
    o_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("post_rst_no_emit", 64'(o_valid), 64'd0);
    end

    // fairness: all channels permanently requesting
    for (int c = 0; c < CH; c++) i_array[c*IW +: IW] = 32'hC0DE0000 + 32'(c);
    i_valid = 4'hF;
    step();
    check("fair_first_o_valid", 64'(o_valid), 64'd0);
    for (int k = 0; k < 8; k++) begin
      step();
      check("fair_o_valid", 64'(o_valid), 64'd1);
      check("fair_o_channel", 64'(o_channel), 64'(k % CH));
      check("fair_o_array", 64'(o_array), 64'(32'hC0DE0000 + 32'(k % CH)));
      step();
      check("fair_gap", 64'(o_valid), 64'd0);
    end
    i_valid = '0;

    // refresh stimulus: one capture on channel 0
    do_reset();
    o_ready = 1'b1;
    i_array[0 +: IW] = 32'hAAAA5555;
    i_valid = 4'b0001;
    step();
    i_valid = '0;
    emits = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (o_valid) begin
        emits++;
        check("ref_o_channel", 64'(o_channel), 64'd0);
        check("ref_o_array", 64'(o_array), 64'hAAAA5555);
      end
    end
`ifdef METER_SCHED_REFRESH_EN
    check("ref_emits_min", 64'(emits >= 4), 64'd1);
`else
    check("ref_emits", 64'(emits), 64'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/meter_channel_scheduler.md
# meter_channel_scheduler

Round-robin scheduler that shares one level-meter display path between several per-channel meter pipelines. Each channel pipeline delivers an `indicator_width`-bit bar/peak array over valid/ready. The scheduler buffers one array per channel and serialises them, tagged with the channel index, onto a single output stream for the downstream display/LED driver. It sits between the per-channel meter outputs and the shared display driver.

## Interface

**Parameters**
- `channel_count`, 2: number of requesting channels, 2..8.
- `indicator_width`, 32: bits per meter array.
- `refresh_period`, 1000000: clock cycles between forced re-emissions; used only with `METER_SCHED_REFRESH_EN`.

**Ports**
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-high reset.
- `i_valid` in `channel_count`: per-channel array valid.
- `i_ready` out `channel_count`: per-channel ready.
- `i_array` in `channel_count*indicator_width`: channel c occupies bits `[c*indicator_width +: indicator_width]`.
- `o_valid` out 1: output valid.
- `o_ready` in 1: downstream ready.
- `o_channel` out `CW`: index of the channel being emitted. `CW = max(1, $clog2(channel_count))`.
- `o_array` out `indicator_width`: array being emitted.

## Operation

- **Per-channel state:**
  - `buf[c]` holds `indicator_width` bits.
  - `pending[c]` is 1 bit.
  - `i_ready[c] = !pending[c]`. This is registered state only, with no combinational path from `o_ready`.
- **Capture:** `i_valid[c] && i_ready[c]` at an edge loads `buf[c] <= i_array` slice and sets `pending[c] <= 1`.
- **Round-robin pointer:** `rr` is `CW` bits and points to the highest-priority channel.
- **State machine states:** IDLE and SEND.
  - IDLE:
    - If any `pending` is set, grant the first set bit searching `rr, rr+1, …, channel_count-1, 0, …` (wrap modulo `channel_count`).
    - Load `o_array <= buf[g]` and `o_channel <= g`.
    - Clear `pending[g]`, set `o_valid <= 1`, and go to SEND.
    - Otherwise stay in IDLE.
  - SEND:
    - `o_valid`, `o_channel` and `o_array` are held stable.
    - On `o_valid && o_ready`: `o_valid <= 0`, `rr <= (g == channel_count-1) ? 0 : g+1`, go to IDLE.
- **Buffer release:** `pending[g]` clears at the grant, so channel g may deliver a new array while its previous one is still in SEND. Output data never changes while `o_valid` is high.
- **Grant and capture on the same channel:** these cannot occur in the same cycle (`i_ready` is 0 while pending).
- **Reset mid-operation:** reset asserted at any time aborts the in-flight transfer and discards all buffers. No partial state survives.

## Timing

- **Reset values:**
  - `o_valid=0`, `o_channel=0`, `o_array=0`.
  - `i_ready` all ones.
  - `rr=0`, state IDLE.
  - All `buf` zero, all `pending` zero.
- **Latency:** input accepted at edge k with the scheduler in IDLE and no other pending channel → `o_valid=1` after edge k+1.
- **Throughput:** at most one output transfer every 2 cycles (IDLE→SEND→IDLE).
- **Handshake:** valid/ready per AXI-stream rules.
  - `o_valid` does not depend on `o_ready`.
  - Once raised, `o_valid` stays high until the handshake completes.
- **Fairness:** with all channels permanently pending, the grant order is 0,1,…,`channel_count-1`,0,… and no channel waits more than `channel_count` grants.

## Configuration

- **`METER_SCHED_REFRESH_EN` defined:**
  - A free-running counter counts 0..`refresh_period-1`.
  - On wrap it sets `pending[c]` for every channel whose `stored[c]` flag is set. `stored[c]` is set by the first capture after reset.
  - The re-emission uses the unchanged `buf[c]`.
  - If `pending[c]` is already set, the wrap has no additional effect.
  - If the wrap coincides with a grant of channel c, c stays pending, so the channel is re-sent.
- **`METER_SCHED_REFRESH_EN` undefined:**
  - No counter and no `stored` flags.
  - Arrays are emitted only when newly captured.

## Test plan

- **Single capture:** after reset, pulse `i_valid[1]` with array `0x0000FFFF` → `o_valid` high one cycle later with `o_channel=1`, `o_array=0x0000FFFF`. `i_ready[1]` returns to 1 at the grant.
- **Fairness:** hold `i_valid` high on all 4 channels (`channel_count=4`) with `o_ready=1` → `o_channel` sequence 0,1,2,3,0,1…, one transfer per 2 cycles.
- **Backpressure:** `o_ready=0` for 10 cycles with `o_valid` high → `o_array`/`o_channel` stable. A new array from the same channel is captured and `i_ready` then drops to 0.
- **Reset mid-SEND:** assert `reset` while `o_valid=1` → all outputs return to reset values immediately. No stale emission occurs after reset release.
- **Refresh, macro defined:** `refresh_period=16`, capture `0xAAAA5555` on channel 0 only → the same array is re-emitted every 16 cycles. Channel 1 is never emitted.
- **Refresh, macro undefined:** same stimulus → exactly one emission.
